imm_gen_stage: RTL and testbench

- Registered, parametrised immediate-generation stage for the AdamRiscv decode path.
- Decodes the immediate of each accepted instruction. Sign-extends to XLEN; RV64 is supported.
- Adds shift-amount (shamt) and CSR zimm formats, a format code, an illegal-opcode flag and a sideband tag.
- Buffers results in a 2-entry skid queue with valid/ready handshakes on both sides. Counts accepted branches for debug.

---
 rtl/imm_gen_stage.sv | 203 ++++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// ---------------------------------------------------------------------------
// imm_gen_stage
//
// Registered immediate-generation stage for the AdamRiscv decode path.
// Each accepted instruction is decoded combinationally into a sign-extended
// immediate, a format code and an illegal-opcode flag. The result is pushed
// with its sideband tag into a 2-entry FIFO that feeds the consumer through a
// valid/ready handshake. A saturating counter tracks accepted branches for
// debug.
//
// Parameters
//   XLEN   : datapath width, 32 or 64
//   TAG_W  : sideband tag width (normally the PC)
//   CSR_EN : 1 lets SYSTEM opcodes with funct3[2]=1 decode as zimm
//   CNT_W  : width of the saturating branch counter
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   flush       in   synchronous queue flush
//   in_valid    in   input instruction valid
//   in_ready    out  stage can accept an input (registered state only)
//   in_inst     in   32-bit instruction word
//   in_tag      in   sideband tag
//   out_valid   out  head entry valid
//   out_ready   in   consumer accepts the head entry
//   out_imm     out  decoded immediate of the head entry
//   out_fmt     out  format: 0 NONE 1 I 2 S 3 B 4 U 5 J 6 Z 7 SH
//   out_illegal out  head entry opcode not recognised
//   out_tag     out  tag of the head entry
//   br_count    out  saturating count of accepted B-type instructions
// ---------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 32,
  parameter int CSR_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] br_count
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_SH   = 3'd7
  } fmt_e;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  fmt_e            w_fmt;
  logic            w_illegal;
  logic [31:0]     w_shamt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;

  logic            w_push;
  logic            w_pop;
  logic            w_wrPtr;

  logic [XLEN-1:0]  r_imm     [0:1];
  logic [2:0]       r_fmt     [0:1];
  logic             r_illegal [0:1];
  logic [TAG_W-1:0] r_tag     [0:1];
  logic             r_head;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_brCount;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];

  // RV64 shifts use a 6-bit shamt; the extra bit belongs to funct7 on RV32
  // and must not leak into the immediate there.
  assign w_shamt = (XLEN == 64) ? {26'b0, in_inst[25:20]}
                                : {27'b0, in_inst[24:20]};

  // Opcode classification into a format code and the illegal flag.
  always_comb begin
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      7'b0000011, 7'b1100111: w_fmt = FMT_I;
      // funct3 001 (slli) and 101 (srli/srai) are the shift-immediate forms
      7'b0010011: w_fmt = (w_funct3[1:0] == 2'b01) ? FMT_SH : FMT_I;
      7'b0100011: w_fmt = FMT_S;
      7'b1100011: w_fmt = FMT_B;
      7'b0110111, 7'b0010111: w_fmt = FMT_U;
      7'b1101111: w_fmt = FMT_J;
      7'b1110011: begin
        if ((CSR_EN != 0) && w_funct3[2]) begin
          w_fmt = FMT_Z;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Immediate assembly in 32 bits. Zero-extended formats keep bit 31 clear,
  // so a single sign extension to XLEN afterwards is correct for all formats.
  always_comb begin
    w_imm32 = 32'b0;
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S:   w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B:   w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0};
      FMT_U:   w_imm32 = {in_inst[31:12], 12'b0};
      FMT_J:   w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                          in_inst[20], in_inst[30:21], 1'b0};
      FMT_Z:   w_imm32 = {27'b0, in_inst[19:15]};
      FMT_SH:  w_imm32 = w_shamt;
      default: w_imm32 = 32'b0;
    endcase
  end

  generate
    if (XLEN == 32) begin : g_xlen32
      assign w_imm = w_imm32;
    end else begin : g_xlenWide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end
  endgenerate

  // Handshakes. in_ready looks only at the registered occupancy so the
  // producer never sees a combinational path from out_ready.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  // Tail slot is head + count modulo 2; a push never happens at count 2.
  assign w_wrPtr   = r_head ^ r_count[0];

  // Queue storage, head pointer and occupancy. A flush empties the queue
  // and wins over a same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_imm[i]     <= '0;
        r_fmt[i]     <= 3'd0;
        r_illegal[i] <= 1'b0;
        r_tag[i]     <= '0;
      end
    end else if (flush) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_imm[w_wrPtr]     <= w_imm;
        r_fmt[w_wrPtr]     <= w_fmt;
        r_illegal[w_wrPtr] <= w_illegal;
        r_tag[w_wrPtr]     <= in_tag;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_head  <= r_head ^ w_pop;
    end
  end

  // Branch counter counts every accepted B-type, even one discarded by a
  // same-cycle flush, and sticks at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brCount <= '0;
    end else if (w_push && (w_fmt == FMT_B) && (r_brCount != {CNT_W{1'b1}})) begin
      r_brCount <= r_brCount + 1'b1;
    end
  end

  assign br_count = r_brCount;

  // Head entry is presented only while valid; an empty queue drives zeros.
  always_comb begin
    out_imm     = '0;
    out_fmt     = 3'd0;
    out_illegal = 1'b0;
    out_tag     = '0;
    if (out_valid) begin
      out_imm     = r_imm[r_head];
      out_fmt     = r_fmt[r_head];
      out_illegal = r_illegal[r_head];
      out_tag     = r_tag[r_head];
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_stage
//
// Directed bench for imm_gen_stage. Two instances share one stimulus stream:
// dut32 uses XLEN=32 with a 16-bit branch counter, dut64 uses XLEN=64 with a
// 2-bit branch counter so saturation shows up early.
// ---------------------------------------------------------------------------
module tb_imm_gen_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic [31:0] inInst;
  logic [31:0] inTag;
  logic        outReady;

  logic        inReady32;
  logic        outValid32;
  logic [31:0] outImm32;
  logic [2:0]  outFmt32;
  logic        outIllegal32;
  logic [31:0] outTag32;
  logic [15:0] brCount32;

  logic        inReady64;
  logic        outValid64;
  logic [63:0] outImm64;
  logic [2:0]  outFmt64;
  logic        outIllegal64;
  logic [31:0] outTag64;
  logic [1:0]  brCount64;

  int checkCount;
  int errorCount;

  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] ADDI = 32'h00100093;

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .CSR_EN(1), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady32), .in_inst(inInst), .in_tag(inTag),
    .out_valid(outValid32), .out_ready(outReady), .out_imm(outImm32),
    .out_fmt(outFmt32), .out_illegal(outIllegal32), .out_tag(outTag32),
    .br_count(brCount32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32), .CSR_EN(1), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady64), .in_inst(inInst), .in_tag(inTag),
    .out_valid(outValid64), .out_ready(outReady), .out_imm(outImm64),
    .out_fmt(outFmt64), .out_illegal(outIllegal64), .out_tag(outTag64),
    .br_count(brCount64)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison with its own tag, counted and reported on a miss.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Offer one instruction for a single edge; called at a falling edge and
  // returns at the next falling edge with the result already in the queue.
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] tag);
    inValid = 1'b1;
    inInst  = inst;
    inTag   = tag;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    @(negedge clk);
  endtask

  // Directed sequence: reset, decode of every format, branch counting and
  // saturation, stall ordering, flush and asynchronous reset.
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    inInst   = 32'b0;
    inTag    = 32'b0;
    outReady = 1'b0;
    #12 rst = 1'b0;
    @(negedge clk);

    checkOutput("rst_valid32", {63'b0, outValid32}, 64'd0);
    checkOutput("rst_ready32", {63'b0, inReady32}, 64'd1);
    checkOutput("rst_imm32", {32'b0, outImm32}, 64'd0);
    checkOutput("rst_br32", {48'b0, brCount32}, 64'd0);
    checkOutput("rst_valid64", {63'b0, outValid64}, 64'd0);
    checkOutput("rst_tag64", {32'b0, outTag64}, 64'd0);

    outReady = 1'b1;
    applyStimulus(32'h123450B7, 32'h100);
    checkOutput("lui_valid32", {63'b0, outValid32}, 64'd1);
    checkOutput("lui_imm32", {32'b0, outImm32}, 64'h12345000);
    checkOutput("lui_fmt32", {61'b0, outFmt32}, 64'd4);
    checkOutput("lui_tag32", {32'b0, outTag32}, 64'h100);
    checkOutput("lui_imm64", outImm64, 64'h0000000012345000);

    applyStimulus(32'h800000B7, 32'h104);
    checkOutput("luineg_imm64", outImm64, 64'hFFFFFFFF80000000);
    checkOutput("luineg_imm32", {32'b0, outImm32}, 64'h80000000);

    applyStimulus(BEQ, 32'h108);
    checkOutput("beq_imm32", {32'b0, outImm32}, 64'hFFFFFFFC);
    checkOutput("beq_fmt32", {61'b0, outFmt32}, 64'd3);
    checkOutput("beq_imm64", outImm64, 64'hFFFFFFFFFFFFFFFC);
    checkOutput("beq_br32_1", {48'b0, brCount32}, 64'd1);
    checkOutput("beq_br64_1", {62'b0, brCount64}, 64'd1);
    applyStimulus(BEQ, 32'h10C);
    applyStimulus(BEQ, 32'h110);
    applyStimulus(BEQ, 32'h114);
    checkOutput("beq_br32_4", {48'b0, brCount32}, 64'd4);
    checkOutput("beq_br64_sat", {62'b0, brCount64}, 64'd3);
    applyStimulus(BEQ, 32'h118);
    checkOutput("beq_br32_5", {48'b0, brCount32}, 64'd5);
    checkOutput("beq_br64_hold", {62'b0, brCount64}, 64'd3);

    applyStimulus(32'h43F05013, 32'h11C);
    checkOutput("srai_imm64", outImm64, 64'h3F);
    checkOutput("srai_fmt64", {61'b0, outFmt64}, 64'd7);
    checkOutput("srai_imm32", {32'b0, outImm32}, 64'h1F);

    applyStimulus(32'h300FD073, 32'h120);
    checkOutput("csrrwi_imm64", outImm64, 64'h1F);
    checkOutput("csrrwi_fmt64", {61'b0, outFmt64}, 64'd6);

    applyStimulus(32'h0000007F, 32'h124);
    checkOutput("bad_imm64", outImm64, 64'd0);
    checkOutput("bad_fmt64", {61'b0, outFmt64}, 64'd0);
    checkOutput("bad_ill64", {63'b0, outIllegal64}, 64'd1);

    applyStimulus(32'h00000073, 32'h128);
    checkOutput("ecall_fmt32", {61'b0, outFmt32}, 64'd0);
    checkOutput("ecall_ill32", {63'b0, outIllegal32}, 64'd0);

    applyStimulus(32'h00A12423, 32'h12C);
    checkOutput("sw_imm32", {32'b0, outImm32}, 64'd8);
    checkOutput("sw_fmt32", {61'b0, outFmt32}, 64'd2);

    applyStimulus(32'hFFF00093, 32'h130);
    checkOutput("addi_imm64", outImm64, 64'hFFFFFFFFFFFFFFFF);
    checkOutput("addi_fmt64", {61'b0, outFmt64}, 64'd1);

    applyStimulus(32'h0080006F, 32'h134);
    checkOutput("jal_imm32", {32'b0, outImm32}, 64'd8);
    checkOutput("jal_fmt32", {61'b0, outFmt32}, 64'd5);

    // Stall with three offers; only two fit, order must be preserved.
    @(negedge clk);
    outReady = 1'b0;
    inValid  = 1'b1;
    inInst   = ADDI;
    inTag    = 32'hA;
    @(negedge clk);
    checkOutput("stall_tagA", {32'b0, outTag32}, 64'hA);
    checkOutput("stall_ready1", {63'b0, inReady32}, 64'd1);
    inTag = 32'hB;
    @(negedge clk);
    checkOutput("stall_full", {63'b0, inReady32}, 64'd0);
    checkOutput("stall_holdA", {32'b0, outTag32}, 64'hA);
    inTag = 32'hC;
    @(negedge clk);
    checkOutput("stall_full2", {63'b0, inReady64}, 64'd0);
    checkOutput("stall_holdA2", {32'b0, outTag64}, 64'hA);
    checkOutput("stall_holdImm", {32'b0, outImm32}, 64'd1);
    checkOutput("stall_valid", {63'b0, outValid32}, 64'd1);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("drain_tagB", {32'b0, outTag32}, 64'hB);
    checkOutput("drain_ready", {63'b0, inReady32}, 64'd1);
    @(negedge clk);
    checkOutput("drain_tagC", {32'b0, outTag32}, 64'hC);
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("drain_empty", {63'b0, outValid32}, 64'd0);
    checkOutput("drain_emptyTag", {32'b0, outTag32}, 64'd0);

    // Flush at full occupancy: the offered branch cannot be accepted.
    outReady = 1'b0;
    applyStimulus(BEQ, 32'h200);
    applyStimulus(BEQ, 32'h204);
    checkOutput("fl_full", {63'b0, inReady32}, 64'd0);
    checkOutput("fl_br7", {48'b0, brCount32}, 64'd7);
    flush   = 1'b1;
    inValid = 1'b1;
    inInst  = BEQ;
    inTag   = 32'h208;
    @(negedge clk);
    flush   = 1'b0;
    inValid = 1'b0;
    checkOutput("fl_valid", {63'b0, outValid32}, 64'd0);
    checkOutput("fl_ready", {63'b0, inReady32}, 64'd1);
    checkOutput("fl_brKeep", {48'b0, brCount32}, 64'd7);

    // Flush at occupancy one: the branch is accepted, counted, discarded.
    applyStimulus(ADDI, 32'h20C);
    flush   = 1'b1;
    inValid = 1'b1;
    inInst  = BEQ;
    inTag   = 32'h210;
    @(negedge clk);
    flush   = 1'b0;
    inValid = 1'b0;
    checkOutput("fl1_valid", {63'b0, outValid32}, 64'd0);
    checkOutput("fl1_br8", {48'b0, brCount32}, 64'd8);
    checkOutput("fl1_imm", {32'b0, outImm32}, 64'd0);

    // Asynchronous reset between edges with one entry held.
    applyStimulus(32'hFFF00093, 32'h300);
    checkOutput("ar_pre", {63'b0, outValid32}, 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_valid", {63'b0, outValid32}, 64'd0);
    checkOutput("ar_br32", {48'b0, brCount32}, 64'd0);
    checkOutput("ar_br64", {62'b0, brCount64}, 64'd0);
    checkOutput("ar_imm", {32'b0, outImm32}, 64'd0);
    checkOutput("ar_tag", {32'b0, outTag32}, 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("ar_ready", {63'b0, inReady32}, 64'd1);
    checkOutput("ar_validPost", {63'b0, outValid64}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
